// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pid_pkg
//  Description : Shared constants and FSM state type for the PID controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

    localparam int PID_FRAC_BITS = 8;   // fractional bits of the Q8.8 gains
    localparam int PID_ACC_W     = 40;  // sum / integral accumulator width
    localparam int E_W           = 17;  // signed error / delta-error width
    localparam int PROD_W        = 34;  // signed 17x17 product width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_MUL_D = 3'd4,
        ST_SUM   = 3'd5,
        ST_OUT   = 3'd6
    } pid_state_e;

endpackage
`default_nettype wire

// File: rtl/pid_sat.sv
`default_nettype none
// ============================================================================
//  Module      : pid_sat
//  Description : Signed saturator, clamps a value to [-lim - EXTRA_NEG, +lim]
//                and narrows it to OUT_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_sat #(
    parameter int IN_W      = 17,
    parameter int OUT_W     = 16,
    parameter int LIM_W     = 15,
    parameter int EXTRA_NEG = 0     // 1 lets the negative bound reach -lim-1
) (
    input  logic signed [IN_W-1:0]  din_i,
    input  logic        [LIM_W-1:0] lim_i,
    output logic signed [OUT_W-1:0] dout_o
);

    logic signed [IN_W-1:0] w_hi;
    logic signed [IN_W-1:0] w_lo;

    assign w_hi = $signed({{(IN_W-LIM_W){1'b0}}, lim_i});
    assign w_lo = -w_hi - IN_W'(EXTRA_NEG);

    // Clamp to the bounds; in-range values pass through, narrowed to OUT_W.
    always_comb begin
        dout_o = din_i[OUT_W-1:0];
        if (din_i > w_hi) begin
            dout_o = w_hi[OUT_W-1:0];
        end else if (din_i < w_lo) begin
            dout_o = w_lo[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pid_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pid_ctrl
//  Description : Sequential fixed-point PID controller with one shared
//                17x17 signed multiplier, integral anti-windup clamp and a
//                runtime output magnitude limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_ctrl
    import pid_pkg::*;
#(
    parameter int FRAC_BITS = PID_FRAC_BITS,
    parameter int ACC_W     = PID_ACC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               tick,
    input  logic signed [15:0] setpoint,
    input  logic signed [15:0] measured,
    input  logic        [15:0] kp,
    input  logic        [15:0] ki,
    input  logic        [15:0] kd,
    input  logic        [14:0] out_lim,
    output logic signed [15:0] pid_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    pid_state_e state_q, state_d;

    logic signed [15:0]       sp_q, meas_q;
    logic        [15:0]       kp_q, ki_q, kd_q;
    logic        [14:0]       lim_q;
    logic signed [15:0]       e_q, e_prev_q;
    logic signed [E_W-1:0]    de_q;
    logic signed [PROD_W-1:0] p_q, d_q;
    logic signed [ACC_W-1:0]  i_acc_q, y_q;
    logic signed [15:0]       pid_out_q;
    logic                     out_valid_q, overrun_q;

    logic signed [E_W-1:0]      w_diff, w_de;
    logic signed [15:0]         w_e_sat;
    logic signed [E_W-1:0]      w_mul_a, w_mul_b;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_i_sum, w_i_clamped, w_sum, w_y;
    logic        [15+FRAC_BITS-1:0] w_i_lim;
    logic signed [15:0]         w_out_clamped;

    // Error: 17-bit difference saturated to the full signed 16-bit range.
    assign w_diff = {sp_q[15], sp_q} - {meas_q[15], meas_q};

    pid_sat #(.IN_W(E_W), .OUT_W(16), .LIM_W(15), .EXTRA_NEG(1)) u_sat_err (
        .din_i  (w_diff),
        .lim_i  (15'h7FFF),
        .dout_o (w_e_sat)
    );

    assign w_de = {w_e_sat[15], w_e_sat} - {e_prev_q[15], e_prev_q};

    // Shared multiplier operand mux: gain (zero-extended) times e or de.
    always_comb begin
        w_mul_a = $signed({1'b0, kp_q});
        w_mul_b = {e_q[15], e_q};
        case (state_q)
            ST_MUL_I: w_mul_a = $signed({1'b0, ki_q});
            ST_MUL_D: begin
                w_mul_a = $signed({1'b0, kd_q});
                w_mul_b = de_q;
            end
            default: ;
        endcase
    end

    assign w_prod = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);

    // Integral update with anti-windup clamp at +/-(out_lim << FRAC_BITS).
    assign w_i_sum = i_acc_q + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_i_lim = {lim_q, {FRAC_BITS{1'b0}}};

    pid_sat #(.IN_W(ACC_W), .OUT_W(ACC_W), .LIM_W(15+FRAC_BITS), .EXTRA_NEG(0)) u_sat_int (
        .din_i  (w_i_sum),
        .lim_i  (w_i_lim),
        .dout_o (w_i_clamped)
    );

    // Sum of terms, then floor-scale back out of the Q8.8 domain.
    assign w_sum = {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q} + i_acc_q
                 + {{(ACC_W-PROD_W){d_q[PROD_W-1]}}, d_q};
    assign w_y   = w_sum >>> FRAC_BITS;

    pid_sat #(.IN_W(ACC_W), .OUT_W(16), .LIM_W(15), .EXTRA_NEG(0)) u_sat_out (
        .din_i  (y_q),
        .lim_i  (lim_q),
        .dout_o (w_out_clamped)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one pass through the pipeline per accepted tick.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (tick) state_d = ST_ERR;
                ST_ERR:   state_d = ST_MUL_P;
                ST_MUL_P: state_d = ST_MUL_I;
                ST_MUL_I: state_d = ST_MUL_D;
                ST_MUL_D: state_d = ST_SUM;
                ST_SUM:   state_d = ST_OUT;
                ST_OUT:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath registers, advanced by the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= '0;
            meas_q      <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            lim_q       <= '0;
            e_q         <= '0;
            de_q        <= '0;
            e_prev_q    <= '0;
            p_q         <= '0;
            d_q         <= '0;
            i_acc_q     <= '0;
            y_q         <= '0;
            pid_out_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (!en) begin
            i_acc_q     <= '0;
            e_prev_q    <= '0;
            pid_out_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            // Any tick outside IDLE (including the OUT cycle) is dropped.
            overrun_q   <= tick && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        sp_q   <= setpoint;
                        meas_q <= measured;
                        kp_q   <= kp;
                        ki_q   <= ki;
                        kd_q   <= kd;
                        lim_q  <= out_lim;
                    end
                end
                ST_ERR: begin
                    e_q  <= w_e_sat;
                    de_q <= w_de;
                end
                ST_MUL_P: p_q     <= w_prod;
                ST_MUL_I: i_acc_q <= w_i_clamped;
                ST_MUL_D: d_q     <= w_prod;
                ST_SUM:   y_q     <= w_y;
                ST_OUT: begin
                    pid_out_q   <= w_out_clamped;
                    e_prev_q    <= e_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pid_out   = pid_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
